fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads under a credit limit, buffers in-order
// responses in a prefetch queue and hands them to decode; redirects flush and drop in-flight data.
module fetch_unit #(
   parameter int              ADDR_W   = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter int              DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               fd_valid,
   input  logic               fd_ready,
   output logic [INSTR_W-1:0] fd_instr,
   output logic [ADDR_W-1:0]  fd_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready; a
   // valid request holds its address until accepted, except across a redirect.

   logic [ADDR_W-1:0]  req_pc;
   logic [ADDR_W-1:0]  rsp_pc;
   logic [CNT_W-1:0]   out_cnt;
   logic [CNT_W-1:0]   drop_cnt;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic [INSTR_W-1:0] instr_q [DEPTH];

   logic credit_ok;
   logic fire;
   logic drop_rsp;
   logic push;
   logic pop;

   // Outstanding requests plus buffered entries never exceed DEPTH, so every
   // live response is guaranteed a free slot.
   assign credit_ok      = ({1'b0, out_cnt} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
   assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
   assign imem_req_addr  = req_pc;
   assign fire           = imem_req_valid && imem_req_ready;

   assign drop_rsp = imem_rsp_valid && (drop_cnt != '0);
   assign push     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

   assign fd_valid = (count != '0) && !redirect_valid;
   assign fd_instr = instr_q[head];
   assign fd_pc    = pc_q[head];
   assign pop      = fd_valid && fd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc   <= RESET_PC;
         rsp_pc   <= RESET_PC;
         out_cnt  <= '0;
         drop_cnt <= '0;
         count    <= '0;
         head     <= '0;
         tail     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else begin
         out_cnt <= out_cnt + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
         if (redirect_valid) begin
            // Everything still in flight is stale, including a response landing now.
            req_pc   <= redirect_pc;
            rsp_pc   <= redirect_pc;
            drop_cnt <= out_cnt - CNT_W'(imem_rsp_valid);
            count    <= '0;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (fire) begin
               req_pc <= req_pc + ADDR_W'(1);
            end
            if (drop_rsp) begin
               drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
               pc_q[tail]    <= rsp_pc;
               instr_q[tail] <= imem_rsp_data;
               tail          <= tail + PTR_W'(1);
               rsp_pc        <= rsp_pc + ADDR_W'(1);
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == CNT_W'(DEPTH))));

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (out_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model, decode-side scoreboard of
// {pc, instr} pairs, and scenario tasks for streaming, backpressure, redirects and reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [15:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [15:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        fd_valid;
   logic        fd_ready = 1'b1;
   logic [15:0] fd_instr;
   logic [15:0] fd_pc;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int mem_lat = 1;
   int last_due = 0;
   logic [15:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_addr = '0;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .fd_valid(fd_valid), .fd_ready(fd_ready),
      .fd_instr(fd_instr), .fd_pc(fd_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Memory: capture accepted requests mid-cycle, return them in order after mem_lat cycles.
   always @(negedge clk) begin
      if (rst_n && imem_req_valid && imem_req_ready) begin
         int d;
         d = cyc + mem_lat;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(d);
      end
   end

   always @(posedge clk) begin
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
         last_due = 0;
      end else if (pend_due.size() != 0 && pend_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_f(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
   end

   // Scoreboard: every accepted request since the last redirect must reach decode in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !redirect_valid) begin
            n_total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr)
               $display("FAIL hold_addr: valid=%0b addr=%h, required valid=1 addr=%h",
                        imem_req_valid, imem_req_addr, prev_addr);
            else n_pass++;
         end
         if (redirect_valid) begin
            n_total++;
            if (fd_valid !== 1'b0 || imem_req_valid !== 1'b0)
               $display("FAIL redirect_quiet: fd_valid=%0b req_valid=%0b, required 0 0",
                        fd_valid, imem_req_valid);
            else n_pass++;
            exp_q.delete();
         end else if (fd_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL stale_fd: fd_pc=%h valid with nothing expected", fd_pc);
            end else begin
               if ({fd_pc, fd_instr} !== exp_q[0])
                  $display("FAIL fd_data: pc/instr=%h/%h, required %h/%h",
                           fd_pc, fd_instr, exp_q[0][31:16], exp_q[0][15:0]);
               else n_pass++;
               if (fd_ready) void'(exp_q.pop_front());
            end
         end
         if (imem_req_valid && imem_req_ready)
            exp_q.push_back({imem_req_addr, mem_f(imem_req_addr)});
         prev_stall = imem_req_valid && !imem_req_ready;
         prev_addr  = imem_req_addr;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Ends at the start of the first cycle after release (cycle 1).
   task automatic do_reset(input int lat);
      step();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      fd_ready = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat = lat;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_total++;
      if (imem_req_valid !== 1'b0 || fd_valid !== 1'b0)
         $display("FAIL %s_valids: req=%0b fd=%0b, required 0 0", tag, imem_req_valid, fd_valid);
      else n_pass++;
      n_total++;
      if (imem_req_addr !== 16'h0000)
         $display("FAIL %s_addr: %h, required 0000", tag, imem_req_addr);
      else n_pass++;
      n_total++;
      if (fd_pc !== 16'h0000 || fd_instr !== 16'h0000)
         $display("FAIL %s_fd: pc=%h instr=%h, required 0000 0000", tag, fd_pc, fd_instr);
      else n_pass++;
   endtask

   // Waits up to 20 cycles for fd_valid; returns the cycle index it appeared in (-1 on timeout).
   task automatic wait_fd(input int start_c, output int seen_c);
      int c;
      c = start_c;
      seen_c = -1;
      for (int k = 0; k < 20 && seen_c < 0; k++) begin
         @(negedge clk);
         if (fd_valid === 1'b1) seen_c = c;
         else begin
            step();
            c++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
   endtask

   task automatic test_stream();
      do_reset(1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         n_total++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'(c - 1))
            $display("FAIL stream_req c%0d: valid=%0b addr=%h, required 1 %h",
                     c, imem_req_valid, imem_req_addr, 16'(c - 1));
         else n_pass++;
         n_total++;
         if (fd_valid !== (c >= 3) || (c >= 3 && fd_pc !== 16'(c - 3)))
            $display("FAIL stream_fd c%0d: valid=%0b pc=%h, required %0b %h",
                     c, fd_valid, fd_pc, (c >= 3), 16'(c - 3));
         else n_pass++;
         step();
      end
   endtask

   task automatic test_backpressure();
      int fires;
      fires = 0;
      do_reset(1);
      fd_ready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) fires++;
         step();
      end
      n_total++;
      if (fires !== 4) $display("FAIL bp_fires: %0d, required 4", fires);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (fd_valid !== 1'b1 || imem_req_valid !== 1'b0)
         $display("FAIL bp_full: fd_valid=%0b req_valid=%0b, required 1 0", fd_valid, imem_req_valid);
      else n_pass++;
      step();
      fd_ready = 1'b1;
      for (int d = 1; d <= 4; d++) begin
         @(negedge clk);
         n_total++;
         if (fd_valid !== 1'b1 || (d <= 2 && imem_req_valid !== (d == 2)))
            $display("FAIL bp_drain d%0d: fd_valid=%0b req_valid=%0b", d, fd_valid, imem_req_valid);
         else n_pass++;
         step();
      end
      repeat (4) step();
   endtask

   task automatic test_redirect_drop();
      int seen;
      do_reset(3);
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      step();
      redirect_valid = 1'b0;
      wait_fd(4, seen);
      n_total++;
      if (seen !== 8 || fd_pc !== 16'h0100)
         $display("FAIL redir_first: cycle=%0d pc=%h, required cycle 8 pc 0100", seen, fd_pc);
      else n_pass++;
      repeat (6) step();
   endtask

   task automatic test_redirect_collide();
      int seen;
      do_reset(2);
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0200;
      @(negedge clk);
      n_total++;
      if (fd_valid !== 1'b0)
         $display("FAIL collide_fd: fd_valid=%0b, required 0", fd_valid);
      else n_pass++;
      step();
      redirect_valid = 1'b0;
      wait_fd(8, seen);
      n_total++;
      if (seen !== 11 || fd_pc !== 16'h0200 || fd_instr !== mem_f(16'h0200))
         $display("FAIL collide_first: cycle=%0d pc=%h instr=%h, required 11 0200 %h",
                  seen, fd_pc, fd_instr, mem_f(16'h0200));
      else n_pass++;
      repeat (6) step();
   endtask

   task automatic test_wrap();
      logic [15:0] want[4];
      logic [15:0] got[4];
      int n;
      want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      n = 0;
      do_reset(1);
      step();
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFE;
      step();
      redirect_valid = 1'b0;
      for (int k = 0; k < 20 && n < 4; k++) begin
         @(negedge clk);
         if (fd_valid === 1'b1 && fd_ready) begin
            got[n] = fd_pc;
            n++;
         end
         step();
      end
      n_total++;
      if (n !== 4) $display("FAIL wrap_count: %0d instructions, required 4", n);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
         n_total++;
         if (got[i] !== want[i]) $display("FAIL wrap_pc%0d: %h, required %h", i, got[i], want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random_reset();
      do_reset($urandom_range(1, 3));
      repeat (80) begin
         imem_req_ready = 1'($urandom_range(0, 1));
         fd_ready = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc = 16'($urandom);
         step();
      end
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      step();
      rst_n = 1'b1;
      imem_req_ready = 1'b1;
      fd_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000)
         $display("FAIL restart: valid=%0b addr=%h, required 1 0000", imem_req_valid, imem_req_addr);
      else n_pass++;
      repeat (10) step();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_collide();
      test_wrap();
      test_random_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
